// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the basic-gate BIST engine and its golden model.
package gate_bist_pkg;

  localparam int NUM_VEC   = 4;
  localparam int NUM_GATES = 6;

  // Bit positions of each gate output within the observed/expected vector
  localparam int OBS_NOT_A = 0;
  localparam int OBS_NOT_B = 1;
  localparam int OBS_AND   = 2;
  localparam int OBS_OR    = 3;
  localparam int OBS_XOR   = 4;
  localparam int OBS_NAND  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef logic [NUM_GATES-1:0] gate_vec_t;

endpackage

// File: rtl/gate_golden.sv
// Combinational reference for the gate cluster: maps {a,b} to the six expected outputs.
module gate_golden
  import gate_bist_pkg::*;
(
  input  logic      a,
  input  logic      b,
  output gate_vec_t expected
);

  // Build the expected vector one gate at a time, bit order matching obs
  always_comb begin
    expected            = '0;
    expected[OBS_NOT_A] = ~a;
    expected[OBS_NOT_B] = ~b;
    expected[OBS_AND]   = a & b;
    expected[OBS_OR]    = a | b;
    expected[OBS_XOR]   = a ^ b;
    expected[OBS_NAND]  = ~(a & b);
  end

endmodule

// File: rtl/gate_bist.sv
// BIST engine: walks {a,b} through 00..11, holds each vector SETTLE cycles,
// samples obs once per vector and accumulates per-gate and per-vector failures.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_GATES-1:0] obs,
  output logic                 a,
  output logic                 b,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] err_mask,
  output logic [NUM_VEC-1:0]   fail_vec,
  output logic [1:0]           vec_idx
);

  // Counter only needs to hold SETTLE-1; keep at least one bit for SETTLE=1
  localparam int             CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]  RELOAD = CW'(SETTLE - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  gate_vec_t     expected;
  gate_vec_t     mism;
  gate_vec_t     err_next;

  gate_golden u_golden (
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  // a/b come straight from registers, so the comparison is stable throughout SAMPLE
  assign mism     = obs ^ expected;
  assign err_next = err_mask | mism;

  // Run sequencer: abort beats everything, otherwise IDLE->APPLY->SAMPLE(x4)->DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_mask <= '0;
      fail_vec <= '0;
      vec_idx  <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        state    <= IDLE;
        cnt      <= '0;
        a        <= 1'b0;
        b        <= 1'b0;
        busy     <= 1'b0;
        pass     <= 1'b0;
        err_mask <= '0;
        fail_vec <= '0;
        vec_idx  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= APPLY;
              cnt      <= RELOAD;
              {a, b}   <= 2'b00;
              vec_idx  <= 2'd0;
              busy     <= 1'b1;
              pass     <= 1'b0;
              err_mask <= '0;
              fail_vec <= '0;
            end
          end
          APPLY: begin
            if (cnt == '0) state <= SAMPLE;
            else           cnt   <= cnt - CW'(1);
          end
          SAMPLE: begin
            err_mask <= err_next;
            if (mism != '0) fail_vec[vec_idx] <= 1'b1;
            if (vec_idx != 2'd3) begin
              vec_idx <= vec_idx + 2'd1;
              {a, b}  <= vec_idx + 2'd1;
              cnt     <= RELOAD;
              state   <= APPLY;
            end else begin
              // pass must include the final vector's result, hence err_next
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end
          end
          DONE: begin
            state   <= IDLE;
            a       <= 1'b0;
            b       <= 1'b0;
            vec_idx <= 2'd0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
